// File: rtl/nearest_target_scanner.sv
// Snapshots player/target positions on start, then scans one slot per cycle against an external
// distance stage and reports the nearest in-range valid target. Optional: NEAREST_EARLY_EXIT_EN.
module nearest_target_scanner #(
    parameter int unsigned NUM_TARGETS = 8,
    parameter int unsigned IDX_W       = $clog2(NUM_TARGETS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [2:0]               player_x_i,
    input  logic [2:0]               player_y_i,
    input  logic [3*NUM_TARGETS-1:0] tgt_x_i,
    input  logic [3*NUM_TARGETS-1:0] tgt_y_i,
    input  logic [NUM_TARGETS-1:0]   tgt_valid_i,
    output logic [3:0]               diff_x_o,
    output logic [3:0]               diff_y_o,
    input  logic [2:0]               dist_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     found_o,
    output logic [IDX_W-1:0]         nearest_idx_o,
    output logic [2:0]               nearest_dist_o
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_TARGETS - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                   state_q;
    logic [IDX_W-1:0]         idx_q;
    logic [2:0]               px_q, py_q;
    logic [3*NUM_TARGETS-1:0] tx_q, ty_q;
    logic [NUM_TARGETS-1:0]   tv_q;
    logic                     busy_q, done_q, found_q;
    logic [IDX_W-1:0]         nidx_q;
    logic [2:0]               ndist_q;

    logic [2:0] cur_x, cur_y;
    logic [3:0] dx, dy, abs_x, abs_y;
    logic       cand, take, last, exit_early;

    always_comb begin
        cur_x = tx_q[idx_q*3 +: 3];
        cur_y = ty_q[idx_q*3 +: 3];
        dx    = {1'b0, cur_x} - {1'b0, px_q};
        dy    = {1'b0, cur_y} - {1'b0, py_q};
        abs_x = dx[3] ? 4'(-dx) : dx;
        abs_y = dy[3] ? 4'(-dy) : dy;
        // dist_i is only meaningful inside the +/-4 window of the distance stage
        cand  = tv_q[idx_q] && (abs_x <= 4'd4) && (abs_y <= 4'd4);
        take  = cand && (!found_q || (dist_i < ndist_q));
        last  = (idx_q == LastIdx);
`ifdef NEAREST_EARLY_EXIT_EN
        exit_early = take && (dist_i == 3'd0);
`else
        exit_early = 1'b0;
`endif
        diff_x_o = (state_q == StScan) ? dx : 4'd0;
        diff_y_o = (state_q == StScan) ? dy : 4'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            tv_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            nidx_q  <= '0;
            ndist_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        px_q    <= player_x_i;
                        py_q    <= player_y_i;
                        tx_q    <= tgt_x_i;
                        ty_q    <= tgt_y_i;
                        tv_q    <= tgt_valid_i;
                        idx_q   <= '0;
                        found_q <= 1'b0;
                        nidx_q  <= '0;
                        ndist_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    if (take) begin
                        found_q <= 1'b1;
                        nidx_q  <= idx_q;
                        ndist_q <= dist_i;
                    end
                    if (last || exit_early) begin
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign found_o        = found_q;
    assign nearest_idx_o  = nidx_q;
    assign nearest_dist_o = ndist_q;

endmodule

// File: tb/tb_nearest_target_scanner.sv
// Randomised and directed checks of nearest_target_scanner against a slot-list reference model.
module tb_nearest_target_scanner;
    localparam int N = 8;
    localparam int W = 3;

    logic           clk = 1'b0;
    logic           rst, start;
    logic [2:0]     player_x, player_y;
    logic [3*N-1:0] tgt_x, tgt_y;
    logic [N-1:0]   tgt_valid;
    logic [3:0]     diff_x, diff_y;
    logic [2:0]     dist_in;
    logic           busy, done, found;
    logic [W-1:0]   nearest_idx;
    logic [2:0]     nearest_dist;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nearest_target_scanner #(.NUM_TARGETS(N)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .player_x_i    (player_x),
        .player_y_i    (player_y),
        .tgt_x_i       (tgt_x),
        .tgt_y_i       (tgt_y),
        .tgt_valid_i   (tgt_valid),
        .diff_x_o      (diff_x),
        .diff_y_o      (diff_y),
        .dist_i        (dist_in),
        .busy_o        (busy),
        .done_o        (done),
        .found_o       (found),
        .nearest_idx_o (nearest_idx),
        .nearest_dist_o(nearest_dist)
    );

    // Distance stage: Chebyshev distance inside the window, 0 outside it.
    function automatic logic [2:0] dist_model(input logic [3:0] dx, input logic [3:0] dy);
        int sx, sy, ax, ay;
        sx = $signed(dx);
        sy = $signed(dy);
        ax = (sx < 0) ? -sx : sx;
        ay = (sy < 0) ? -sy : sy;
        if (ax > 4 || ay > 4) return 3'd0;
        return 3'((ax > ay) ? ax : ay);
    endfunction

    assign dist_in = dist_model(diff_x, diff_y);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_scan(input string tag, input logic [2:0] px, input logic [2:0] py,
                           input logic [3*N-1:0] tx, input logic [3*N-1:0] ty,
                           input logic [N-1:0] tv, input bit scramble);
        int  exp_done, done_cyc, ndone, ex_idx, ex_dist, dx, dy, ax, ay, d;
        bit  ex_found;
        logic [3:0] edx, edy;
        ex_found = 0; ex_idx = 0; ex_dist = 0; exp_done = N + 1;
        for (int i = 0; i < N; i++) begin
            dx = int'(tx[3*i +: 3]) - int'(px);
            dy = int'(ty[3*i +: 3]) - int'(py);
            ax = (dx < 0) ? -dx : dx;
            ay = (dy < 0) ? -dy : dy;
            if (tv[i] && ax <= 4 && ay <= 4) begin
                d = (ax > ay) ? ax : ay;
                if (!ex_found || d < ex_dist) begin
                    ex_found = 1; ex_idx = i; ex_dist = d;
                end
`ifdef NEAREST_EARLY_EXIT_EN
                if (d == 0 && exp_done == N + 1) exp_done = i + 2;
`endif
            end
        end
        done_cyc = -1;
        ndone    = 0;
        for (int c = 0; c <= N + 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                player_x = px; player_y = py; tgt_x = tx; tgt_y = ty; tgt_valid = tv;
                start = 1'b1;
            end else begin
                start = scramble && c == 3 && exp_done > 4;
                if (scramble) begin
                    player_x = 3'($urandom); player_y = 3'($urandom);
                    tgt_x = 24'($urandom); tgt_y = 24'($urandom); tgt_valid = 8'($urandom);
                end
            end
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            check_eq({tag, " busy"}, busy, (c <= exp_done - 2) ? 1 : 0);
            if (c <= exp_done - 2) begin
                edx = 4'(int'(tx[3*c +: 3]) - int'(px));
                edy = 4'(int'(ty[3*c +: 3]) - int'(py));
            end else begin
                edx = 4'd0;
                edy = 4'd0;
            end
            check_eq({tag, " diff_x"}, diff_x, edx);
            check_eq({tag, " diff_y"}, diff_y, edy);
        end
        start = 1'b0;
        check_eq({tag, " done_cycle"}, done_cyc, exp_done);
        check_eq({tag, " done_count"}, ndone, 1);
        check_eq({tag, " found"}, found, ex_found);
        check_eq({tag, " idx"}, nearest_idx, ex_idx);
        check_eq({tag, " dist"}, nearest_dist, ex_dist);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, " busy"}, busy, 0);
        check_eq({tag, " done"}, done, 0);
        check_eq({tag, " found"}, found, 0);
        check_eq({tag, " idx"}, nearest_idx, 0);
        check_eq({tag, " dist"}, nearest_dist, 0);
        check_eq({tag, " diff_x"}, diff_x, 0);
        check_eq({tag, " diff_y"}, diff_y, 0);
    endtask

    logic [3*N-1:0] tx, ty;
    logic [N-1:0]   tv;
    int             ndone;

    initial begin
        rst = 1'b1; start = 1'b0;
        player_x = '0; player_y = '0; tgt_x = '0; tgt_y = '0; tgt_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk) rst = 1'b0;

        tx = '0; ty = '0; tv = '0;
        tx[0 +: 3] = 3'd7; ty[0 +: 3] = 3'd7;
        tx[3 +: 3] = 3'd4; ty[3 +: 3] = 3'd5;
        tx[6 +: 3] = 3'd2; ty[6 +: 3] = 3'd3;
        tv[2:0] = 3'b111;
        do_scan("basic", 3'd3, 3'd3, tx, ty, tv, 1'b0);

        tx = '0; ty = '0; tv = '0;
        tx[3 +: 3] = 3'd1; ty[3 +: 3] = 3'd1;
        tx[12 +: 3] = 3'd1; ty[12 +: 3] = 3'd1;
        tv[1] = 1'b1; tv[4] = 1'b1;
        do_scan("tie", 3'd0, 3'd0, tx, ty, tv, 1'b0);

        tx = '0; ty = '0; tv = '0;
        tx[9 +: 3] = 3'd6; ty[9 +: 3] = 3'd1; tv[3] = 1'b1;
        do_scan("range", 3'd0, 3'd0, tx, ty, tv, 1'b0);

        tx = 24'($urandom); ty = 24'($urandom); tv = 8'hff;
        do_scan("restart", 3'd3, 3'd4, tx, ty, tv, 1'b1);

        tx = 24'($urandom); ty = 24'($urandom); tv = 8'($urandom);
        tx[6 +: 3] = 3'd2; ty[6 +: 3] = 3'd2; tv[2] = 1'b1;
        tx[5:0] = 6'o77; ty[5:0] = 6'o77;
        do_scan("early", 3'd2, 3'd2, tx, ty, tv, 1'b0);

        // Reset in the middle of a scan
        @(negedge clk);
        player_x = 3'd3; player_y = 3'd3; tgt_x = '0; tgt_y = '0; tgt_valid = 8'hff;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midrst");
        @(negedge clk) rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < N + 4; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check_eq("midrst no_done", ndone, 0);

        for (int t = 0; t < 40; t++) begin
            tx = 24'($urandom); ty = 24'($urandom); tv = 8'($urandom);
            do_scan("rand", 3'($urandom), 3'($urandom), tx, ty, tv, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
